// File: rtl/flash_reader_pkg.sv
// Shared helpers for the SPI flash reader: byte ordering and word-address stepping.
package flash_reader_pkg;

    // First byte shifted in lands in [31:24]; the bus wants it in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [21:0] next_word(input logic [21:0] w);
        return w + 22'd1;
    endfunction

endpackage

// File: rtl/flash_reader_spi_shifter.sv
// SPI mode-0 bit engine: one 32-bit word per load, each bit is a low then a high
// clk phase; the incoming bit is sampled on the edge that ends the high phase.
module flash_spi_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic        run_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        shift_o,
    output logic        done_o,
    output logic [5:0]  bits_left_o,
    output logic [31:0] rx_word_o
);
    localparam logic [5:0] WORD_BITS = 6'd32;

    logic [31:0] sr_q;
    logic [5:0]  cnt_q;
    logic        phase_q;
    logic        mosi_q;
    logic        active;
    logic        unused_sr_msb;

    assign active      = run_i && (cnt_q != 6'd0);
    assign shift_o     = active && phase_q;
    assign done_o      = shift_o && (cnt_q == 6'd1);
    assign rx_word_o   = {sr_q[30:0], miso_i};
    assign sclk_o      = phase_q;
    assign mosi_o      = mosi_q;
    assign bits_left_o = cnt_q;
    // The MSB leaves through mosi_q one edge early, so the register copy is never read.
    assign unused_sr_msb = sr_q[31];

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            mosi_q  <= 1'b0;
        end else if (load_i) begin
            sr_q    <= load_word_i;
            cnt_q   <= WORD_BITS;
            phase_q <= 1'b0;
            mosi_q  <= load_word_i[31];
        end else if (active) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
                sr_q   <= rx_word_o;
                cnt_q  <= cnt_q - 6'd1;
                mosi_q <= sr_q[30] & ~done_o;
            end
        end else begin
            phase_q <= 1'b0;
            mosi_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/flash_reader.sv
// SPI flash word reader with sequential-read streaming: a request for the word
// right after the previous one reuses the open transaction and skips CMD/ADDR.
module flash_reader #(
    parameter logic [7:0] READ_CMD     = 8'h03,
    parameter int         CSN_MIN_HIGH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flash_read_en,
    input  logic [23:0] address,
    output logic        flash_read_ready,
    output logic [31:0] flash_read_data,
    output logic        flash_csn,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);
    import flash_reader_pkg::*;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, DONE, HOLDOFF, STREAM, CSN_WAIT
    } state_e;

    // Bits still pending in the shifter when the last opcode bit is sampled.
    localparam logic [5:0] CMD_LAST_LEFT  = 6'd25;
    localparam int         HOLDOFF_CYCLES = 2;
    localparam logic [7:0] HOLD_INIT      = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0] CSN_INIT       = 8'(CSN_MIN_HIGH - 1);

    state_e      state_q, state_d;
    logic        csn_q, csn_d;
    logic        ready_q, ready_d;
    logic [31:0] data_q, data_d;
    logic [21:0] waddr_q, waddr_d;
    logic [21:0] next_q, next_d;
    logic        nvld_q, nvld_d;
    logic        ok_q, ok_d;
    logic [7:0]  wait_q, wait_d;

    logic        sh_load, sh_run, sh_shift, sh_done, accept;
    logic [31:0] sh_word, sh_rx;
    logic [5:0]  sh_left;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[1:0];

    flash_spi_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (sh_load),
        .load_word_i (sh_word),
        .run_i       (sh_run),
        .miso_i      (flash_miso),
        .sclk_o      (flash_clk),
        .mosi_o      (flash_mosi),
        .shift_o     (sh_shift),
        .done_o      (sh_done),
        .bits_left_o (sh_left),
        .rx_word_o   (sh_rx)
    );

    always_comb begin
        state_d = state_q;
        csn_d   = csn_q;
        ready_d = 1'b0;
        data_d  = data_q;
        waddr_d = waddr_q;
        next_d  = next_q;
        nvld_d  = nvld_q;
        ok_d    = ok_q;
        wait_d  = wait_q;
        sh_load = 1'b0;
        sh_word = '0;
        sh_run  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            IDLE: accept = flash_read_en;
            CMD: begin
                sh_run = 1'b1;
                if (!flash_read_en) ok_d = 1'b0;
                if (sh_shift && sh_left == CMD_LAST_LEFT) state_d = ADDR;
            end
            ADDR: begin
                sh_run = 1'b1;
                if (!flash_read_en) ok_d = 1'b0;
                if (sh_done) begin
                    sh_load = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                sh_run = 1'b1;
                if (!flash_read_en) ok_d = 1'b0;
                if (sh_done) begin
                    data_d  = bswap32(sh_rx);
                    // A requester that let go mid-transfer gets the data but no pulse.
                    ready_d = ok_q & flash_read_en;
                    next_d  = next_word(waddr_q);
                    nvld_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                wait_d  = HOLD_INIT;
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (wait_q == 8'd0) state_d = STREAM;
                else                wait_d  = wait_q - 8'd1;
            end
            STREAM: begin
                if (flash_read_en) begin
                    if (nvld_q && address[23:2] == next_q) begin
                        sh_load = 1'b1;
                        waddr_d = next_q;
                        ok_d    = 1'b1;
                        state_d = DATA;
                    end else begin
                        csn_d   = 1'b1;
                        wait_d  = CSN_INIT;
                        state_d = CSN_WAIT;
                    end
                end
            end
            CSN_WAIT: begin
                if (wait_q != 8'd0)     wait_d  = wait_q - 8'd1;
                else if (flash_read_en) accept  = 1'b1;
                else                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sh_load = 1'b1;
            sh_word = {READ_CMD, address[23:2], 2'b00};
            waddr_d = address[23:2];
            csn_d   = 1'b0;
            ok_d    = 1'b1;
            state_d = CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            csn_q   <= 1'b1;
            ready_q <= 1'b0;
            data_q  <= '0;
            waddr_q <= '0;
            next_q  <= '0;
            nvld_q  <= 1'b0;
            ok_q    <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            csn_q   <= csn_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
            next_q  <= next_d;
            nvld_q  <= nvld_d;
            ok_q    <= ok_d;
            wait_q  <= wait_d;
        end
    end

    assign flash_read_ready = ready_q;
    assign flash_read_data  = data_q;
    assign flash_csn        = csn_q;

endmodule

// File: tb/tb_flash_reader.sv
// Self-checking bench for flash_reader: SPI flash model plus a read-data scoreboard.
module tb_flash_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        flash_read_en;
    logic [23:0] address;
    logic        flash_read_ready;
    logic [31:0] flash_read_data;
    logic        flash_csn;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    flash_reader dut (
        .clk              (clk),
        .reset            (reset),
        .flash_read_en    (flash_read_en),
        .address          (address),
        .flash_read_ready (flash_read_ready),
        .flash_read_data  (flash_read_data),
        .flash_csn        (flash_csn),
        .flash_clk        (flash_clk),
        .flash_mosi       (flash_mosi),
        .flash_miso       (flash_miso)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
    endfunction

    // Flash model: sees sclk rising edges from the negedge of clk, collects 32
    // command/address bits, then streams bytes MSB-first while csn stays low.
    logic [31:0] mdl_cmd = '0;
    logic [31:0] last_cmd = '0;
    logic [23:0] mdl_addr = '0;
    logic [7:0]  mdl_byte;
    logic        mdl_prev_sclk = 1'b0;
    int          mdl_bits = 0;
    int          mdl_total = 0;
    int          mdl_bib = 0;
    int          cmd_count = 0;

    initial flash_miso = 1'b0;

    always @(negedge clk) begin
        if (flash_csn !== 1'b0) begin
            mdl_bits  = 0;
            mdl_total = 0;
        end else if (flash_clk === 1'b1 && mdl_prev_sclk === 1'b0) begin
            mdl_total++;
            if (mdl_bits < 32) begin
                mdl_cmd = {mdl_cmd[30:0], flash_mosi};
                mdl_bits++;
                if (mdl_bits == 32) begin
                    mdl_addr  = mdl_cmd[23:0];
                    last_cmd  = mdl_cmd;
                    cmd_count++;
                    mdl_bib   = 0;
                end
            end else begin
                mdl_byte   = mem_byte(mdl_addr);
                flash_miso = mdl_byte[7 - mdl_bib];
                mdl_bib++;
                if (mdl_bib == 8) begin
                    mdl_bib  = 0;
                    mdl_addr = mdl_addr + 24'd1;
                end
            end
        end
        mdl_prev_sclk = flash_clk;
    end

    // Scoreboard: every ready pulse must match the oldest expected word.
    logic        ready_prev = 1'b0;
    logic [31:0] sb_exp;
    always @(negedge clk) begin
        if (flash_read_ready === 1'b1) begin
            if (ready_prev) begin
                checks++; failures++;
                $display("FAIL ready_consecutive: ready high two cycles in a row");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready: data=%h with no request outstanding", flash_read_data);
            end else begin
                sb_exp = sb.pop_front();
                if (flash_read_data !== sb_exp) begin
                    failures++;
                    $display("FAIL read_data: got %h expected %h", flash_read_data, sb_exp);
                end
            end
        end
        ready_prev = (flash_read_ready === 1'b1);
    end

    task automatic issue(input logic [23:0] a, input bit expect_ready);
        address       = a;
        flash_read_en = 1'b1;
        if (expect_ready) sb.push_back(exp_word(a));
    endtask

    // Counts posedges from the request until ready is seen, watching csn/sclk on the way.
    task automatic wait_ready(input int limit, output int cyc, output int csn_hi,
                              output int clk_viol, output bit seen);
        cyc = 0; csn_hi = 0; clk_viol = 0; seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (flash_csn === 1'b1) csn_hi++;
            if (flash_clk === 1'b1 && flash_csn === 1'b1) clk_viol++;
            if (flash_read_ready === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flash_read_en = 1'b0; address = '0;
        repeat (4) @(negedge clk);
        checks++; if (flash_csn !== 1'b1)        begin failures++; $display("FAIL reset_csn: got %b expected 1", flash_csn); end
        checks++; if (flash_clk !== 1'b0)        begin failures++; $display("FAIL reset_sclk: got %b expected 0", flash_clk); end
        checks++; if (flash_mosi !== 1'b0)       begin failures++; $display("FAIL reset_mosi: got %b expected 0", flash_mosi); end
        checks++; if (flash_read_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", flash_read_ready); end
        checks++; if (flash_read_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", flash_read_data); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fresh_read();
        int cyc, hi, viol, c0; bit seen;
        c0 = cmd_count;
        issue(24'h000100, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 129)                 begin failures++; $display("FAIL fresh_latency: got %0d expected 129", cyc); end
        checks++; if (last_cmd !== 32'h03000100)   begin failures++; $display("FAIL fresh_cmd: got %h expected 03000100", last_cmd); end
        checks++; if (cmd_count !== c0 + 1)        begin failures++; $display("FAIL fresh_cmd_count: got %0d expected %0d", cmd_count, c0 + 1); end
        checks++; if (flash_read_data !== 32'h44332211) begin failures++; $display("FAIL fresh_data: got %h expected 44332211", flash_read_data); end
        @(negedge clk);
        checks++; if (flash_read_ready !== 1'b0)   begin failures++; $display("FAIL ready_width: got %b expected 0", flash_read_ready); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stream();
        int cyc, hi, viol, c0; bit seen;
        c0 = cmd_count;
        issue(24'h000104, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 65)           begin failures++; $display("FAIL stream_latency: got %0d expected 65", cyc); end
        checks++; if (hi !== 0)             begin failures++; $display("FAIL stream_csn: csn high %0d cycles expected 0", hi); end
        checks++; if (cmd_count !== c0)     begin failures++; $display("FAIL stream_no_cmd: got %0d commands expected %0d", cmd_count, c0); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_csn_wait();
        int cyc, hi, viol, c0; bit seen;
        c0 = cmd_count;
        issue(24'h000200, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 131)                 begin failures++; $display("FAIL redirect_latency: got %0d expected 131", cyc); end
        checks++; if (hi !== 2)                    begin failures++; $display("FAIL redirect_csn_high: got %0d expected 2", hi); end
        checks++; if (last_cmd !== 32'h03000200)   begin failures++; $display("FAIL redirect_cmd: got %h expected 03000200", last_cmd); end
        checks++; if (viol !== 0 || cmd_count !== c0 + 1) begin failures++; $display("FAIL redirect_bus: sclk_viol=%0d cmds=%0d expected 0/%0d", viol, cmd_count, c0 + 1); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_wrap();
        int cyc, hi, viol, c0; bit seen;
        issue(24'hFFFFFC, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (last_cmd !== 32'h03FFFFFC)   begin failures++; $display("FAIL wrap_first_cmd: got %h expected 03fffffc", last_cmd); end
        repeat (6) @(negedge clk);
        c0 = cmd_count;
        issue(24'h000000, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 65)           begin failures++; $display("FAIL wrap_latency: got %0d expected 65", cyc); end
        checks++; if (cmd_count !== c0)     begin failures++; $display("FAIL wrap_no_cmd: got %0d expected %0d", cmd_count, c0); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_abort_en();
        int cyc, hi, viol, rdy; bit seen;
        issue(24'h000004, 1'b0);
        repeat (20) @(negedge clk);
        flash_read_en = 1'b0;
        rdy = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (flash_read_ready === 1'b1) rdy++;
        end
        checks++; if (rdy !== 0)                            begin failures++; $display("FAIL abort_ready: got %0d pulses expected 0", rdy); end
        checks++; if (flash_read_data !== exp_word(24'h4))  begin failures++; $display("FAIL abort_data: got %h expected %h", flash_read_data, exp_word(24'h4)); end
        issue(24'h000008, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 65)                           begin failures++; $display("FAIL abort_then_stream: got %0d expected 65", cyc); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, hi, viol, rdy, c0; bit seen;
        issue(24'h000400, 1'b0);
        repeat (83) @(negedge clk);
        checks++; if (mdl_total !== 40) begin failures++; $display("FAIL reset_mid_position: got %0d bits expected 40", mdl_total); end
        reset = 1'b1; flash_read_en = 1'b0;
        @(negedge clk);
        checks++; if (flash_csn !== 1'b1)        begin failures++; $display("FAIL reset_mid_csn: got %b expected 1", flash_csn); end
        checks++; if (flash_clk !== 1'b0)        begin failures++; $display("FAIL reset_mid_sclk: got %b expected 0", flash_clk); end
        checks++; if (flash_read_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_ready: got %b expected 0", flash_read_ready); end
        reset = 1'b0;
        rdy = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (flash_read_ready === 1'b1) rdy++;
        end
        checks++; if (rdy !== 0) begin failures++; $display("FAIL reset_mid_no_ready: got %0d pulses expected 0", rdy); end
        c0 = cmd_count;
        issue(24'h00000C, 1'b1);
        wait_ready(400, cyc, hi, viol, seen);
        flash_read_en = 1'b0;
        checks++; if (cyc !== 129)                 begin failures++; $display("FAIL post_reset_latency: got %0d expected 129", cyc); end
        checks++; if (last_cmd !== 32'h0300000C)   begin failures++; $display("FAIL post_reset_cmd: got %h expected 0300000c", last_cmd); end
        checks++; if (cmd_count !== c0 + 1)        begin failures++; $display("FAIL post_reset_cmd_count: got %0d expected %0d", cmd_count, c0 + 1); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_continuous();
        int pulses, first_at, gap; bit csn_between;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(24'h000500, 1'b1);
        sb.push_back(exp_word(24'h000500));
        pulses = 0; first_at = 0; gap = 0; csn_between = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pulses == 1 && flash_csn === 1'b1) csn_between = 1'b1;
            if (flash_read_ready === 1'b1) begin
                pulses++;
                if (pulses == 1) first_at = i;
                else if (pulses == 2) gap = i - first_at;
            end
        end
        flash_read_en = 1'b0;
        checks++; if (pulses !== 2)       begin failures++; $display("FAIL cont_pulses: got %0d expected 2", pulses); end
        checks++; if (gap < 132)          begin failures++; $display("FAIL cont_gap: got %0d expected >= 132", gap); end
        checks++; if (!csn_between)       begin failures++; $display("FAIL cont_csn_toggle: got 0 expected 1"); end
        repeat (200) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fresh_read();
        test_stream();
        test_csn_wait();
        test_wrap();
        test_abort_en();
        test_reset_mid();
        test_continuous();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drained: %0d expected reads left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 Parameter READ_CMD, default 8'h03, SPI read opcode sent MSB-first.
REQ-002 Parameter CSN_MIN_HIGH, default 2, minimum cycles flash_csn stays high between transactions.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flash_read_en  in  1  read request from the address decoder, held until serviced.
REQ-006 address  in  24  flash byte address; bits [1:0] ignored (word-aligned).
REQ-007 flash_read_ready  out  1  one-cycle pulse, read data valid; feeds the bus arbiter.
REQ-008 flash_read_data  out  32  read word; byte at lowest address in [7:0].
REQ-009 flash_csn  out  1  SPI chip select, active low.
REQ-010 flash_clk  out  1  SPI clock, mode 0, clk/2.
REQ-011 flash_mosi  out  1  SPI data to flash.
REQ-012 flash_miso  in  1  SPI data from flash.

Function
REQ-013 States: IDLE, CMD, ADDR, DATA, DONE, HOLDOFF, STREAM, CSN_WAIT.
REQ-014 Each SPI bit = 2 cycles: flash_clk 0 with mosi driven, then flash_clk 1; miso sampled on the edge ending the high phase.
REQ-015 IDLE plus flash_read_en sampled high at edge E: capture address, csn low from E, enter CMD.
REQ-016 CMD shifts 8 opcode bits, ADDR shifts 24 address bits {address[23:2],2'b00}, MSB-first; DATA shifts in 32 bits.
REQ-017 DATA assembles bytes in arrival order into [7:0],[15:8],[23:16],[31:24]; each byte MSB-first.
REQ-018 Fresh transaction: flash_read_ready high for exactly the one cycle following edge E+128.
REQ-019 flash_read_data updates only on the final DATA sample and holds until the next transaction's final sample.
REQ-020 After DONE, enter HOLDOFF for 2 cycles ignoring flash_read_en, then STREAM with csn still low.
REQ-021 Next-address register = captured word address + 4, wrapping modulo 2^24.
REQ-022 STREAM plus request equal to next-address: skip CMD/ADDR, enter DATA directly; ready follows 64 cycles after acceptance edge.
REQ-023 STREAM plus request not equal: raise csn, CSN_WAIT for CSN_MIN_HIGH cycles, then behave as IDLE acceptance.
REQ-024 flash_clk is 0 whenever csn is high, in STREAM, HOLDOFF and CSN_WAIT.
REQ-025 flash_read_en deasserted mid-transfer: transfer completes, data is updated, ready pulse is suppressed, then normal HOLDOFF/STREAM entry.
REQ-026 flash_read_ready never asserts in two consecutive cycles.

Reset
REQ-027 Reset: state IDLE, flash_csn=1, flash_clk=0, flash_mosi=0, flash_read_ready=0, flash_read_data=0, next-address invalid.
REQ-028 Reset mid-transfer: csn high and clk low in the cycle after the reset edge, no ready pulse.
REQ-029 After reset, the first request always performs a full CMD/ADDR transaction.

Structure
REQ-030 State encodings and bit counts are module-local localparams; no shared package is required.
REQ-031 One sub-module, flash_spi_shifter: 32-bit shift register, 6-bit bit counter, clk phase toggle, plus load/shift/done controls.
REQ-032 All outputs are registered.

Verification
REQ-033 Reset, then request 0x000100 with a flash model holding bytes 11,22,33,44 -> mosi 03 00 01 00; ready one cycle after E+128; data 0x44332211.
REQ-034 Follow-up request 0x000104 -> no CMD/ADDR bits and csn stays low; ready after E+64; data from bytes 0x104..0x107.
REQ-035 Request 0x000200 while in STREAM -> csn high for 2 cycles, then a full transaction with address 00 02 00.
REQ-036 Request 0xFFFFFC, then request 0x000000 -> second request streams (wrap) with ready after 64 cycles.
REQ-037 Reset asserted at bit 40 of a transaction -> csn=1, clk=0 next cycle; no ready; next request performs a full transaction.
REQ-038 flash_read_en held high continuously for 300 cycles at a fixed address -> ready pulses spaced by HOLDOFF; never consecutive; csn toggles between pulses.
